// File: rtl/axis_combiner_pkg.sv
// Shared definitions for the AXI-Stream channel combiner.
// Optional feature macro used by the top: AXIS_COMBINER_LAST_CHECK_EN.
package axis_combiner_pkg;

    // Default geometry: two 16-bit lanes packed into one 32-bit beat.
    localparam int DEF_IN_DATA_WIDTH = 16;
    localparam int DEF_CHANNELS      = 2;
    localparam int DEF_SIDE_WIDTH    = 1;

    // Per-channel tkeep width: one bit per byte when keep is carried, else a single bit.
    function automatic int keep_width(input int data_width, input bit keep_enable);
        return keep_enable ? (data_width + 7) / 8 : 1;
    endfunction

endpackage

// File: rtl/axis_combiner_slot.sv
// One-deep holding register for a single input channel of the combiner.
// The slot takes a beat when it is empty, or when the top drains every slot
// in the same cycle (simultaneous drain and fill keeps full throughput).
module axis_combiner_slot #(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = 2,
    parameter int SIDE_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [KEEP_WIDTH-1:0] s_keep,
    input  logic                  s_last,
    input  logic [SIDE_WIDTH-1:0] s_side,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  load,
    output logic                  slot_valid,
    output logic [DATA_WIDTH-1:0] slot_data,
    output logic [KEEP_WIDTH-1:0] slot_keep,
    output logic                  slot_last,
    output logic [SIDE_WIDTH-1:0] slot_side
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic [SIDE_WIDTH-1:0] side_q, side_d;
    logic                  accept;

    assign s_ready = !valid_q || load;
    assign accept  = s_valid && s_ready;

    // Next-state: a new beat wins over a drain so that fill and drain can overlap.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        side_d  = side_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = s_data;
            keep_d  = s_keep;
            last_d  = s_last;
            side_d  = s_side;
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy flag is the only reset state of the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Payload registers carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        last_q <= last_d;
        side_q <= side_d;
    end

    assign slot_valid = valid_q;
    assign slot_data  = data_q;
    assign slot_keep  = keep_q;
    assign slot_last  = last_q;
    assign slot_side  = side_q;

endmodule

// File: rtl/axis_combiner.sv
// Joins CHANNELS narrow AXI-Stream inputs into one wide output beat.
// Channel c lands in m_axis_tdata[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]; sideband comes from channel 0.
// Optional: define AXIS_COMBINER_LAST_CHECK_EN to add the sticky last_mismatch flag.
//
// Handshake: a transfer happens on a rising edge where tvalid && tready are both high.
// tvalid never depends on tready; s_axis_tready depends on m_axis_tready only through load.
module axis_combiner
    import axis_combiner_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter bit IN_KEEP_ENABLE = (IN_DATA_WIDTH > 8),
    parameter int IN_KEEP_WIDTH  = keep_width(IN_DATA_WIDTH, IN_KEEP_ENABLE),
    parameter bit LAST_ENABLE    = 1'b1,
    parameter int ID_WIDTH       = DEF_SIDE_WIDTH,
    parameter int DEST_WIDTH     = DEF_SIDE_WIDTH,
    parameter int USER_WIDTH     = DEF_SIDE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS*IN_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*IN_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]               s_axis_tvalid,
    output logic [CHANNELS-1:0]               s_axis_tready,
    input  logic [CHANNELS-1:0]               s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]      s_axis_tid,
    input  logic [CHANNELS*DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [CHANNELS*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [CHANNELS*IN_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CHANNELS*IN_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tid,
    output logic [DEST_WIDTH-1:0]             m_axis_tdest,
    output logic [USER_WIDTH-1:0]             m_axis_tuser
`ifdef AXIS_COMBINER_LAST_CHECK_EN
    ,
    output logic                              last_mismatch
`endif
);

    localparam int SIDE_W = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int DATA_W = CHANNELS * IN_DATA_WIDTH;
    localparam int KEEP_W = CHANNELS * IN_KEEP_WIDTH;

    logic [CHANNELS-1:0]        slot_valid;
    logic [DATA_W-1:0]          slot_data;
    logic [KEEP_W-1:0]          slot_keep;
    logic [CHANNELS-1:0]        slot_last;
    logic [CHANNELS*SIDE_W-1:0] slot_side;
    logic                       load;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic [SIDE_W-1:0] out_side_q, out_side_d;

    // A beat moves out only when every lane holds one and the output can take it.
    assign load = (&slot_valid) && (!out_valid_q || m_axis_tready);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
        axis_combiner_slot #(
            .DATA_WIDTH (IN_DATA_WIDTH),
            .KEEP_WIDTH (IN_KEEP_WIDTH),
            .SIDE_WIDTH (SIDE_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .s_data     (s_axis_tdata[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .s_keep     (IN_KEEP_ENABLE ? s_axis_tkeep[c*IN_KEEP_WIDTH +: IN_KEEP_WIDTH]
                                        : {IN_KEEP_WIDTH{1'b1}}),
            .s_last     (s_axis_tlast[c]),
            .s_side     ({s_axis_tuser[c*USER_WIDTH +: USER_WIDTH],
                          s_axis_tdest[c*DEST_WIDTH +: DEST_WIDTH],
                          s_axis_tid[c*ID_WIDTH +: ID_WIDTH]}),
            .s_valid    (s_axis_tvalid[c]),
            .s_ready    (s_axis_tready[c]),
            .load       (load),
            .slot_valid (slot_valid[c]),
            .slot_data  (slot_data[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .slot_keep  (slot_keep[c*IN_KEEP_WIDTH +: IN_KEEP_WIDTH]),
            .slot_last  (slot_last[c]),
            .slot_side  (slot_side[c*SIDE_W +: SIDE_W])
        );
    end

    // Output register: load refills it, an accepted beat without a refill empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_side_d  = out_side_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = slot_data;
            out_keep_d  = slot_keep;
            out_last_d  = LAST_ENABLE ? slot_last[0] : 1'b0;
            out_side_d  = slot_side[SIDE_W-1:0];
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output valid flag; reset drops any pending beat at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid_q <= 1'b0;
        else     out_valid_q <= out_valid_d;
    end

    // Output payload, qualified by out_valid_q.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
        out_keep_q <= out_keep_d;
        out_last_q <= out_last_d;
        out_side_q <= out_side_d;
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tid    = out_side_q[ID_WIDTH-1:0];
    assign m_axis_tdest  = out_side_q[ID_WIDTH +: DEST_WIDTH];
    assign m_axis_tuser  = out_side_q[ID_WIDTH+DEST_WIDTH +: USER_WIDTH];

`ifdef AXIS_COMBINER_LAST_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Lanes disagreeing on tlast at load means packet framing has drifted apart.
    always_comb begin
        mismatch_d = mismatch_q;
        if (load && (|slot_last) && !(&slot_last)) mismatch_d = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mismatch_q <= 1'b0;
        else     mismatch_q <= mismatch_d;
    end

    assign last_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_axis_combiner.sv
// Self-checking bench for axis_combiner (2 lanes x 16 bits).
// Build with AXIS_COMBINER_LAST_CHECK_EN defined to also exercise last_mismatch.
module tb_axis_combiner;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam int KW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*W-1:0] s_axis_tdata  = '0;
    logic [CH*KW-1:0] s_axis_tkeep = '0;
    logic [CH-1:0]   s_axis_tvalid = '0;
    logic [CH-1:0]   s_axis_tready;
    logic [CH-1:0]   s_axis_tlast  = '0;
    logic [CH-1:0]   s_axis_tid    = '0;
    logic [CH-1:0]   s_axis_tdest  = '0;
    logic [CH-1:0]   s_axis_tuser  = '0;
    logic [CH*W-1:0] m_axis_tdata;
    logic [CH*KW-1:0] m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            m_axis_tid;
    logic            m_axis_tdest;
    logic            m_axis_tuser;
`ifdef AXIS_COMBINER_LAST_CHECK_EN
    logic            last_mismatch;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Lane item: {user, dest, id, last, keep[1:0], data[15:0]}
    logic [21:0] ch0_q[$];
    logic [21:0] ch1_q[$];
    // Expected beat: {user, dest, id, last, keep[3:0], data[31:0]}
    logic [39:0] exp_q[$];

    axis_combiner dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser)
`ifdef AXIS_COMBINER_LAST_CHECK_EN
        ,
        .last_mismatch (last_mismatch)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model helpers ----------------
    function automatic logic [21:0] mk_item(input logic [15:0] d, input logic [1:0] k,
                                            input logic l, input logic [2:0] side);
        return {side, l, k, d};
    endfunction

    // Channel 0 supplies sideband and last; keeps and data are concatenated ch1:ch0.
    function automatic logic [39:0] mk_exp(input logic [21:0] i0, input logic [21:0] i1);
        return {i0[21:19], i0[18], i1[17:16], i0[17:16], i1[15:0], i0[15:0]};
    endfunction

    function automatic logic [21:0] rnd_item(input logic l);
        return mk_item(16'($urandom_range(0, 65535)), 2'b11, l, 3'($urandom_range(0, 7)));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [21:0] i0, input logic [21:0] i1);
        ch0_q.push_back(i0);
        ch1_q.push_back(i1);
        exp_q.push_back(mk_exp(i0, i1));
    endtask

    task automatic set_m_ready(input logic v);
        @(posedge clk);
        #1;
        m_axis_tready = v;
    endtask

    // Lane driver: pops an item once it was accepted, then presents the next one.
    initial begin : lane_driver
        logic [1:0] fire;
        forever begin
            @(negedge clk);
            fire = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                s_axis_tvalid = '0;
            end else begin
                if (fire[0] && ch0_q.size() > 0) void'(ch0_q.pop_front());
                if (fire[1] && ch1_q.size() > 0) void'(ch1_q.pop_front());
                if (ch0_q.size() > 0) begin
                    {s_axis_tuser[0], s_axis_tdest[0], s_axis_tid[0], s_axis_tlast[0],
                     s_axis_tkeep[1:0], s_axis_tdata[15:0]} = ch0_q[0];
                    s_axis_tvalid[0] = 1'b1;
                end else begin
                    s_axis_tvalid[0] = 1'b0;
                end
                if (ch1_q.size() > 0) begin
                    {s_axis_tuser[1], s_axis_tdest[1], s_axis_tid[1], s_axis_tlast[1],
                     s_axis_tkeep[3:2], s_axis_tdata[31:16]} = ch1_q[0];
                    s_axis_tvalid[1] = 1'b1;
                end else begin
                    s_axis_tvalid[1] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [39:0] got;
        logic [39:0] want;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            got = {m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: got unexpected beat %h, want no beat", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL out_beat: got %h, want %h", got, want);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_tvalid: got %b, want 0", m_axis_tvalid);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 2'b11) begin
            n_err++; $display("FAIL reset_tready: got %b, want 11", s_axis_tready);
        end
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_tvalid_post: got %b, want 0", m_axis_tvalid);
        end
`ifdef AXIS_COMBINER_LAST_CHECK_EN
        n_cmp++;
        if (last_mismatch !== 1'b0) begin
            n_err++; $display("FAIL reset_mismatch: got %b, want 0", last_mismatch);
        end
`endif
    endtask

    // ch0 arrives three cycles before ch1; ch0 must stall and the output must wait.
    task automatic test_skew();
        logic [21:0] i1;
        i1 = mk_item(16'h2222, 2'b11, 1'b0, 3'b101);
        @(negedge clk);
        ch0_q.push_back(mk_item(16'h1111, 2'b11, 1'b0, 3'b010));
        exp_q.push_back(mk_exp(mk_item(16'h1111, 2'b11, 1'b0, 3'b010), i1));
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (s_axis_tready[0] !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                n_err++;
                $display("FAIL skew_hold: got ready0=%b tvalid=%b, want ready0=0 tvalid=0",
                         s_axis_tready[0], m_axis_tvalid);
            end
            @(negedge clk);
        end
        ch1_q.push_back(i1);
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 2'b10) begin
            n_err++;
            $display("FAIL skew_present: got tvalid=%b ready=%b, want tvalid=0 ready=10",
                     m_axis_tvalid, s_axis_tready);
        end
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL skew_latency_early: got tvalid=%b, want 0", m_axis_tvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h2222_1111) begin
            n_err++;
            $display("FAIL skew_output: got tvalid=%b tdata=%h, want tvalid=1 tdata=22221111",
                     m_axis_tvalid, m_axis_tdata);
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL skew_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask

    // 100 beats with the sink always ready: output must be one unbroken burst.
    task automatic test_back_to_back();
        int seen;
        int gaps;
        logic l;
        seen = 0;
        gaps = 0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            l = 1'($urandom_range(0, 1));
            send_beat(rnd_item(l), rnd_item(l));
        end
        for (int t = 0; t < 400 && seen < 100; t++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen++;
            else if (seen > 0) gaps++;
        end
        n_cmp++;
        if (seen != 100 || gaps != 0) begin
            n_err++; $display("FAIL b2b_stream: got %0d beats %0d gaps, want 100 beats 0 gaps", seen, gaps);
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_tail: got %0d pending tvalid=%b, want 0 pending tvalid=0",
                     exp_q.size(), m_axis_tvalid);
        end
    endtask

    // Sink stalls: output must hold and inputs must back off, then drain losslessly.
    task automatic test_backpressure();
        set_m_ready(1'b0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_beat(rnd_item(1'b0), rnd_item(1'b0));
        repeat (4) @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 2'b00 || m_axis_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_stall: got ready=%b tvalid=%b, want ready=00 tvalid=1",
                     s_axis_tready, m_axis_tvalid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (m_axis_tdata !== exp_q[0][31:0]) begin
                n_err++; $display("FAIL bp_hold: got %h, want %h", m_axis_tdata, exp_q[0][31:0]);
            end
        end
        set_m_ready(1'b1);
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask

    // Keeps concatenate unchanged (including all-zero), tlast follows channel 0.
    task automatic test_keep_last();
        bit seen;
        seen = 0;
        @(negedge clk);
        send_beat(mk_item(16'hAAAA, 2'b11, 1'b1, 3'b001), mk_item(16'hBBBB, 2'b01, 1'b1, 3'b110));
        send_beat(mk_item(16'hCCCC, 2'b11, 1'b0, 3'b100), mk_item(16'hDDDD, 2'b00, 1'b0, 3'b011));
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1;
        end
        n_cmp++;
        if (m_axis_tkeep !== 4'b0111 || m_axis_tlast !== 1'b1) begin
            n_err++;
            $display("FAIL keep_last: got keep=%b last=%b, want keep=0111 last=1",
                     m_axis_tkeep, m_axis_tlast);
        end
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL keep_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask

    // Reset with a full output and one half-filled slot: both must be discarded.
    task automatic test_reset_mid();
        set_m_ready(1'b0);
        @(negedge clk);
        send_beat(rnd_item(1'b0), rnd_item(1'b0));
        ch0_q.push_back(mk_item(16'hDEAD, 2'b11, 1'b0, 3'b111));
        repeat (4) @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_pre: got tvalid=%b ready=%b, want tvalid=1 ready=10",
                     m_axis_tvalid, s_axis_tready);
        end
        rst = 1'b1;
        ch0_q.delete();
        ch1_q.delete();
        exp_q.delete();
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_tvalid: got %b, want 0", m_axis_tvalid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 2'b11) begin
            n_err++; $display("FAIL rstmid_ready: got %b, want 11", s_axis_tready);
        end
        send_beat(mk_item(16'h0C0C, 2'b11, 1'b0, 3'b000), mk_item(16'h1C1C, 2'b11, 1'b0, 3'b000));
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_post: got %0d pending tvalid=%b, want 0 pending tvalid=0",
                     exp_q.size(), m_axis_tvalid);
        end
    endtask

`ifdef AXIS_COMBINER_LAST_CHECK_EN
    // Disagreeing tlast sets the sticky flag the cycle after load; only reset clears it.
    task automatic test_last_check();
        n_cmp++;
        if (last_mismatch !== 1'b0) begin
            n_err++; $display("FAIL lchk_idle: got %b, want 0", last_mismatch);
        end
        @(negedge clk);
        send_beat(mk_item(16'h5555, 2'b11, 1'b1, 3'b000), mk_item(16'h6666, 2'b11, 1'b0, 3'b000));
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (last_mismatch !== 1'b0) begin
            n_err++; $display("FAIL lchk_early: got %b, want 0", last_mismatch);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (last_mismatch !== 1'b1) begin
                n_err++; $display("FAIL lchk_sticky: got %b, want 1", last_mismatch);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (last_mismatch !== 1'b0) begin
            n_err++; $display("FAIL lchk_reset: got %b, want 0", last_mismatch);
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL lchk_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_skew();
        test_back_to_back();
        test_backpressure();
        test_keep_last();
        test_reset_mid();
`ifdef AXIS_COMBINER_LAST_CHECK_EN
        test_last_check();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
